// File: rtl/reset_seq_pkg.sv
// Shared definitions for the staged reset sequencer: FSM state encoding
// and the constant functions used to size the internal counters.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_RELEASE   = 3'd1,
        ST_RUN       = 3'd2,
        ST_SOFT_HOLD = 3'd3,
        ST_SOFT_ACK  = 3'd4
    } seq_state_e;

    // Larger of two integers, used for elaboration-time sizing.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The shared counter must reach both the stage gap and the soft-hold length.
    function automatic int cnt_width(input int gap, input int hold);
        return $clog2(max_int(gap, hold)) + 1;
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset-release synchroniser: asserts asynchronously, releases after
// SYNC_STAGES rising clock edges so downstream logic sees a clean deassertion.
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_in_n,
    output logic rst_out_n
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Shift ones into the chain once the incoming reset is released.
    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_out_n = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: after the power-on reset is released, deasserts the
// per-subsystem resets one at a time, STAGE_GAP cycles apart, and supports a
// req/ack soft reset that holds every stage low and replays the sequence.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_GAP   = 256,
    parameter int SOFT_HOLD   = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  res_n,
    input  logic                  soft_rst_req,
    output logic                  soft_rst_ack,
    output logic [NUM_STAGES-1:0] stage_res_n,
    output logic                  all_ready,
    output logic [2:0]            seq_state
);

    localparam int CW = cnt_width(STAGE_GAP, SOFT_HOLD);
    localparam int IW = $clog2(NUM_STAGES) + 1;

    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(SOFT_HOLD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

    logic                  rst_sync_s;
    seq_state_e            state_r;
    logic [CW-1:0]         cnt_r;
    logic [IW-1:0]         idx_r;
    logic [NUM_STAGES-1:0] stage_r;
    logic                  ack_r;
    logic                  ready_r;
    logic [NUM_STAGES-1:0] release_mask_s;

    reset_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_reset_sync (
        .clk       (clk),
        .rst_in_n  (res_n),
        .rst_out_n (rst_sync_s)
    );

    // Decode idx into a one-hot mask selecting the stage released next.
    always_comb begin
        release_mask_s = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (idx_r == IW'(i)) begin
                release_mask_s[i] = 1'b1;
            end else begin
                release_mask_s[i] = 1'b0;
            end
        end
    end

    // Sequencer FSM with its gap/hold counter, stage index and registered outputs.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_r <= ST_HOLD;
            cnt_r   <= '0;
            idx_r   <= '0;
            stage_r <= '0;
            ack_r   <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    stage_r <= '0;
                    ack_r   <= 1'b0;
                    ready_r <= 1'b0;
                    cnt_r   <= '0;
                    idx_r   <= '0;
                    if (rst_sync_s) begin
                        state_r <= ST_RELEASE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end

                ST_RELEASE: begin
                    if (cnt_r == GAP_LAST) begin
                        // Released bits are OR-ed in so earlier stages stay out of reset.
                        stage_r <= stage_r | release_mask_s;
                        cnt_r   <= '0;
                        idx_r   <= idx_r + IW'(1);
                        if (idx_r == IDX_LAST) begin
                            state_r <= ST_RUN;
                            ready_r <= 1'b1;
                        end else begin
                            state_r <= ST_RELEASE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end

                ST_RUN: begin
                    if (soft_rst_req) begin
                        state_r <= ST_SOFT_HOLD;
                        stage_r <= '0;
                        ready_r <= 1'b0;
                        cnt_r   <= '0;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end

                ST_SOFT_HOLD: begin
                    // The hold runs to completion even if the request drops early.
                    if (cnt_r == HOLD_LAST) begin
                        state_r <= ST_SOFT_ACK;
                        ack_r   <= 1'b1;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end

                ST_SOFT_ACK: begin
                    if (!soft_rst_req) begin
                        ack_r   <= 1'b0;
                        state_r <= ST_RELEASE;
                        cnt_r   <= '0;
                        idx_r   <= '0;
                    end else begin
                        ack_r <= 1'b1;
                    end
                end

                default: begin
                    state_r <= ST_HOLD;
                    cnt_r   <= '0;
                    idx_r   <= '0;
                    stage_r <= '0;
                    ack_r   <= 1'b0;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign stage_res_n  = stage_r;
    assign soft_rst_ack = ack_r;
    assign all_ready    = ready_r;
    assign seq_state    = state_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus pushes hand-computed
// expectations tagged with the clock edge they apply to; a monitor pops and
// compares them on the following falling edge or on an explicit async check.
module tb_reset_sequencer;

    logic       clk;
    logic       res_n;
    logic       soft_rst_req;
    logic       soft_rst_ack;
    logic [3:0] stage_res_n;
    logic       all_ready;
    logic [2:0] seq_state;

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] stg;
        logic       rdy;
        logic       ack;
        logic [2:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    event chk_ev;

    reset_sequencer #(
        .NUM_STAGES  (4),
        .STAGE_GAP   (8),
        .SOFT_HOLD   (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .res_n        (res_n),
        .soft_rst_req (soft_rst_req),
        .soft_rst_ack (soft_rst_ack),
        .stage_res_n  (stage_res_n),
        .all_ready    (all_ready),
        .seq_state    (seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation whose edge has been reached.
    always begin
        @(negedge clk or chk_ev);
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (stage_res_n !== e.stg || all_ready !== e.rdy ||
                soft_rst_ack !== e.ack || seq_state !== e.st) begin
                bad++;
                $display("FAIL %s @cyc%0d: got stg=%b rdy=%b ack=%b st=%0d, want stg=%b rdy=%b ack=%b st=%0d",
                         e.name, e.cyc, stage_res_n, all_ready, soft_rst_ack, seq_state,
                         e.stg, e.rdy, e.ack, e.st);
            end
        end
    end

    task automatic exp_at(input int c, input string nm, input logic [3:0] stg,
                          input logic rdy, input logic ack, input logic [2:0] st);
        exp_t e;
        e.cyc = c; e.name = nm; e.stg = stg; e.rdy = rdy; e.ack = ack; e.st = st;
        exp_q.push_back(e);
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drop res_n 1 ns after a falling edge, check the immediate reset, release 3 ns later.
    task automatic por_pulse(output int b);
        @(negedge clk);
        #1 res_n = 1'b0;
        #1;
        exp_at(cyc, "async_reset", 4'b0000, 1'b0, 1'b0, 3'd0);
        -> chk_ev;
        #2 res_n = 1'b1;
        b = cyc;
    endtask

    // Expected power-on release timeline relative to the res_n rise.
    task automatic push_por_seq(input int b, input string tag);
        exp_at(b + 2,  {tag, "_hold_e2"},   4'b0000, 1'b0, 1'b0, 3'd0);
        exp_at(b + 3,  {tag, "_release_e3"}, 4'b0000, 1'b0, 1'b0, 3'd1);
        exp_at(b + 10, {tag, "_pre_s0"},    4'b0000, 1'b0, 1'b0, 3'd1);
        exp_at(b + 11, {tag, "_s0"},        4'b0001, 1'b0, 1'b0, 3'd1);
        exp_at(b + 18, {tag, "_pre_s1"},    4'b0001, 1'b0, 1'b0, 3'd1);
        exp_at(b + 19, {tag, "_s1"},        4'b0011, 1'b0, 1'b0, 3'd1);
        exp_at(b + 26, {tag, "_pre_s2"},    4'b0011, 1'b0, 1'b0, 3'd1);
        exp_at(b + 27, {tag, "_s2"},        4'b0111, 1'b0, 1'b0, 3'd1);
        exp_at(b + 34, {tag, "_pre_s3"},    4'b0111, 1'b0, 1'b0, 3'd1);
        exp_at(b + 35, {tag, "_run"},       4'b1111, 1'b1, 1'b0, 3'd2);
    endtask

    initial begin
        int b;
        int e;
        res_n        = 1'b1;
        soft_rst_req = 1'b0;
        #1 res_n = 1'b0;
        wait_edges(3);
        exp_at(cyc, "reset_state", 4'b0000, 1'b0, 1'b0, 3'd0);

        // Test 1: power-on release sequence.
        por_pulse(b);
        push_por_seq(b, "t1");
        wait_edges(40);

        // Test 2: restart from RUN, then a 3 ns reset pulse at edge 22 mid-sequence.
        por_pulse(b);
        exp_at(b + 11, "t2_s0", 4'b0001, 1'b0, 1'b0, 3'd1);
        exp_at(b + 19, "t2_s1", 4'b0011, 1'b0, 1'b0, 3'd1);
        exp_at(b + 22, "t2_e22", 4'b0011, 1'b0, 1'b0, 3'd1);
        wait_edges(22);
        por_pulse(b);
        push_por_seq(b, "t2r");
        wait_edges(40);

        // Test 3: soft reset with request held, released after E+20.
        e = cyc + 1;
        exp_at(e - 1,  "t3_in_run",    4'b1111, 1'b1, 1'b0, 3'd2);
        exp_at(e,      "t3_enter_hold", 4'b0000, 1'b0, 1'b0, 3'd3);
        exp_at(e + 15, "t3_hold_end",  4'b0000, 1'b0, 1'b0, 3'd3);
        exp_at(e + 16, "t3_ack",       4'b0000, 1'b0, 1'b1, 3'd4);
        exp_at(e + 20, "t3_ack_held",  4'b0000, 1'b0, 1'b1, 3'd4);
        exp_at(e + 21, "t3_ack_drop",  4'b0000, 1'b0, 1'b0, 3'd1);
        exp_at(e + 28, "t3_pre_s0",    4'b0000, 1'b0, 1'b0, 3'd1);
        exp_at(e + 29, "t3_s0",        4'b0001, 1'b0, 1'b0, 3'd1);
        exp_at(e + 37, "t3_s1",        4'b0011, 1'b0, 1'b0, 3'd1);
        exp_at(e + 45, "t3_s2",        4'b0111, 1'b0, 1'b0, 3'd1);
        exp_at(e + 53, "t3_run",       4'b1111, 1'b1, 1'b0, 3'd2);
        soft_rst_req = 1'b1;
        wait_edges(21);
        soft_rst_req = 1'b0;
        wait_edges(35);

        // Test 4: single-cycle request still gets the full hold and a one-cycle ack.
        e = cyc + 1;
        exp_at(e,      "t4_enter_hold", 4'b0000, 1'b0, 1'b0, 3'd3);
        exp_at(e + 8,  "t4_mid_hold",  4'b0000, 1'b0, 1'b0, 3'd3);
        exp_at(e + 16, "t4_ack",       4'b0000, 1'b0, 1'b1, 3'd4);
        exp_at(e + 17, "t4_ack_1cyc",  4'b0000, 1'b0, 1'b0, 3'd1);
        exp_at(e + 24, "t4_pre_s0",    4'b0000, 1'b0, 1'b0, 3'd1);
        exp_at(e + 25, "t4_s0",        4'b0001, 1'b0, 1'b0, 3'd1);
        exp_at(e + 49, "t4_run",       4'b1111, 1'b1, 1'b0, 3'd2);
        soft_rst_req = 1'b1;
        wait_edges(1);
        soft_rst_req = 1'b0;
        wait_edges(52);

        // Test 5: request held from edge 5 is ignored until RUN.
        por_pulse(b);
        exp_at(b + 5,  "t5_release",   4'b0000, 1'b0, 1'b0, 3'd1);
        exp_at(b + 11, "t5_s0",        4'b0001, 1'b0, 1'b0, 3'd1);
        exp_at(b + 34, "t5_pre_s3",    4'b0111, 1'b0, 1'b0, 3'd1);
        exp_at(b + 35, "t5_run",       4'b1111, 1'b1, 1'b0, 3'd2);
        exp_at(b + 36, "t5_soft_hold", 4'b0000, 1'b0, 1'b0, 3'd3);
        exp_at(b + 51, "t5_hold_end",  4'b0000, 1'b0, 1'b0, 3'd3);
        exp_at(b + 52, "t5_ack",       4'b0000, 1'b0, 1'b1, 3'd4);
        exp_at(b + 53, "t5_ack_held",  4'b0000, 1'b0, 1'b1, 3'd4);
        wait_edges(4);
        soft_rst_req = 1'b1;
        wait_edges(49);

        // Test 6: res_n dropped while in SOFT_ACK, then a clean recovery.
        soft_rst_req = 1'b0;
        por_pulse(b);
        exp_at(b + 2,  "t6_hold",      4'b0000, 1'b0, 1'b0, 3'd0);
        exp_at(b + 3,  "t6_release",   4'b0000, 1'b0, 1'b0, 3'd1);
        exp_at(b + 35, "t6_run",       4'b1111, 1'b1, 1'b0, 3'd2);
        wait_edges(40);

        total++;
        if (stage_res_n !== 4'b1111) begin
            bad++;
            $display("FAIL final_stages: got %b, want 1111", stage_res_n);
        end
        total++;
        if (all_ready !== 1'b1) begin
            bad++;
            $display("FAIL final_ready: got %b, want 1", all_ready);
        end
        total++;
        if (soft_rst_ack !== 1'b0) begin
            bad++;
            $display("FAIL final_ack: got %b, want 0", soft_rst_ack);
        end
        total++;
        if (seq_state !== 3'd2) begin
            bad++;
            $display("FAIL final_state: got %0d, want 2", seq_state);
        end

        while (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL %s @cyc%0d: got never compared, want checked", x.name, x.cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
